// File: rtl/dm_boot_loader_pkg.sv
// Shared definitions for the data-memory boot loader: size defaults, memory access-type codes, FSM states.
// The BOOT_VERIFY state exists only when DM_BOOT_READBACK_EN is defined.
package dm_boot_loader_pkg;

    localparam int MEM_BYTES_DEF = 512;
    localparam int AW_DEF        = 9;
    localparam int LEN_W_DEF     = 16;

    // Access-type codes shared with the data memory (ctrl_encode_def.v values).
    localparam logic [2:0] DM_WORD          = 3'b000;
    localparam logic [2:0] DM_BYTE          = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED = 3'b100;

    typedef enum logic [2:0] {
        BOOT_IDLE,
        BOOT_LEN0,
        BOOT_LEN1,
        BOOT_DATA,
        BOOT_CSUM,
`ifdef DM_BOOT_READBACK_EN
        BOOT_VERIFY,
`endif
        BOOT_DONE,
        BOOT_ERR
    } boot_state_e;

endpackage

// File: rtl/dm_boot_loader_port_mux.sv
// Combinational ownership switch for the data-memory port: CPU when released, loader otherwise.
module dm_port_mux #(
    parameter int AW = 9
) (
    input  logic          i_sel_cpu,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [31:0]   i_cpu_din,
    input  logic [2:0]    i_cpu_type,
    input  logic          i_ld_we,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [31:0]   i_ld_din,
    input  logic [2:0]    i_ld_type,
    output logic          o_dm_we,
    output logic [AW-1:0] o_dm_addr,
    output logic [31:0]   o_dm_din,
    output logic [2:0]    o_dm_type
);

    // Only the selected source can write, so CPU stores issued while held off are dropped.
    assign o_dm_we   = i_sel_cpu ? i_cpu_we   : i_ld_we;
    assign o_dm_addr = i_sel_cpu ? i_cpu_addr : i_ld_addr;
    assign o_dm_din  = i_sel_cpu ? i_cpu_din  : i_ld_din;
    assign o_dm_type = i_sel_cpu ? i_cpu_type : i_ld_type;

endmodule

// File: rtl/dm_boot_loader.sv
// Boot loader: receives a length/payload/checksum byte frame, writes the payload into data memory,
// then releases the memory port to the CPU. Define DM_BOOT_READBACK_EN to add a read-back verify pass.
module dm_boot_loader
    import dm_boot_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int AW        = AW_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          cpu_DMWr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_din,
    input  logic [2:0]    cpu_DMType,
    output logic          dm_DMWr,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    output logic [2:0]    dm_DMType,
    input  logic [31:0]   dm_dout,
    output logic          cpu_run,
    output logic          busy,
    output logic          done,
    output logic          err
);

    boot_state_e      r_state;
    boot_state_e      w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [7:0]       r_sum;
    logic             r_wr_en;
    logic [AW-1:0]    r_wr_addr;
    logic [7:0]       r_wr_data;

    logic [LEN_W-1:0] w_len_hdr;
    logic             w_cnt_last;
    logic             w_verify;
    logic [AW-1:0]    w_ld_addr;
    logic [2:0]       w_ld_type;

    assign w_len_hdr  = {in_data, r_len[7:0]};
    assign w_cnt_last = (r_cnt == r_len - LEN_W'(1));

`ifdef DM_BOOT_READBACK_EN
    logic [7:0] r_vsum;
    logic [7:0] w_vsum_fin;
    logic       w_unused_dout_hi;

    assign w_vsum_fin       = r_vsum + dm_dout[7:0];
    assign w_unused_dout_hi = ^dm_dout[31:8];
    assign w_verify         = (r_state == BOOT_VERIFY);
`else
    logic w_unused_dout;

    assign w_unused_dout = ^dm_dout;
    assign w_verify      = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= BOOT_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        cpu_run     = 1'b0;
        case (r_state)
            BOOT_IDLE: if (start) w_state_nxt = BOOT_LEN0;
            BOOT_LEN0: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_state_nxt = BOOT_LEN1;
            end
            BOOT_LEN1: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (w_len_hdr > LEN_W'(MEM_BYTES)) w_state_nxt = BOOT_ERR;
                    else if (w_len_hdr == '0)         w_state_nxt = BOOT_CSUM;
                    else                               w_state_nxt = BOOT_DATA;
                end
            end
            BOOT_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && w_cnt_last) w_state_nxt = BOOT_CSUM;
            end
            BOOT_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (in_data != r_sum)   w_state_nxt = BOOT_ERR;
`ifdef DM_BOOT_READBACK_EN
                    else if (r_len != '0)   w_state_nxt = BOOT_VERIFY;
`endif
                    else                    w_state_nxt = BOOT_DONE;
                end
            end
`ifdef DM_BOOT_READBACK_EN
            BOOT_VERIFY: begin
                busy = 1'b1;
                if (w_cnt_last) w_state_nxt = (w_vsum_fin == r_sum) ? BOOT_DONE : BOOT_ERR;
            end
`endif
            BOOT_DONE: begin
                done    = 1'b1;
                cpu_run = 1'b1;
                if (start) w_state_nxt = BOOT_LEN0;
            end
            BOOT_ERR: begin
                err = 1'b1;
                if (start) w_state_nxt = BOOT_LEN0;
            end
            default: w_state_nxt = BOOT_IDLE;
        endcase
    end

    // A byte accepted in DATA is presented to memory on the following cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_len     <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
`ifdef DM_BOOT_READBACK_EN
            r_vsum    <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                BOOT_IDLE, BOOT_DONE, BOOT_ERR: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_sum <= '0;
                    end
                end
                BOOT_LEN0: if (in_valid) r_len[7:0] <= in_data;
                BOOT_LEN1: if (in_valid) r_len[LEN_W-1:8] <= in_data;
                BOOT_DATA: begin
                    if (in_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt[AW-1:0];
                        r_wr_data <= in_data;
                        r_sum     <= r_sum + in_data;
                        r_cnt     <= r_cnt + LEN_W'(1);
                    end
                end
`ifdef DM_BOOT_READBACK_EN
                BOOT_CSUM: begin
                    r_cnt  <= '0;
                    r_vsum <= '0;
                end
                BOOT_VERIFY: begin
                    r_vsum <= w_vsum_fin;
                    r_cnt  <= r_cnt + LEN_W'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign w_ld_addr = w_verify ? r_cnt[AW-1:0] : r_wr_addr;
    assign w_ld_type = w_verify ? DM_BYTE_UNSIGNED : DM_BYTE;

    dm_port_mux #(.AW(AW)) u_port_mux (
        .i_sel_cpu  (cpu_run),
        .i_cpu_we   (cpu_DMWr),
        .i_cpu_addr (cpu_addr),
        .i_cpu_din  (cpu_din),
        .i_cpu_type (cpu_DMType),
        .i_ld_we    (r_wr_en),
        .i_ld_addr  (w_ld_addr),
        .i_ld_din   ({24'b0, r_wr_data}),
        .i_ld_type  (w_ld_type),
        .o_dm_we    (dm_DMWr),
        .o_dm_addr  (dm_addr),
        .o_dm_din   (dm_din),
        .o_dm_type  (dm_DMType)
    );

endmodule

// File: tb/tb_dm_boot_loader.sv
// Directed bench for dm_boot_loader with a byte-addressed memory model behind the dm_* port.
module tb_dm_boot_loader;
    import dm_boot_loader_pkg::*;

`ifdef DM_BOOT_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rstn, start, in_valid, in_ready;
    logic [7:0]  in_data;
    logic        cpu_DMWr, dm_DMWr;
    logic [8:0]  cpu_addr, dm_addr;
    logic [31:0] cpu_din, dm_din, dm_dout;
    logic [2:0]  cpu_DMType, dm_DMType;
    logic        cpu_run, busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:511];
    int         wr_count = 0;
    logic [8:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];

    always #5 clk = ~clk;

    dm_boot_loader dut (
        .clk(clk), .rstn(rstn), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_DMWr(cpu_DMWr), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_DMType(cpu_DMType),
        .dm_DMWr(dm_DMWr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_DMType(dm_DMType),
        .dm_dout(dm_dout), .cpu_run(cpu_run), .busy(busy), .done(done), .err(err)
    );

    always @(posedge clk) begin
        if (dm_DMWr) begin
            wr_count <= wr_count + 1;
            wr_addr_log.push_back(dm_addr);
            wr_data_log.push_back(dm_din[7:0]);
            if (dm_DMType == DM_WORD) begin
                mem[dm_addr]        <= dm_din[7:0];
                mem[dm_addr + 9'd1] <= dm_din[15:8];
                mem[dm_addr + 9'd2] <= dm_din[23:16];
                mem[dm_addr + 9'd3] <= dm_din[31:24];
            end else begin
                mem[dm_addr] <= dm_din[7:0];
            end
        end
    end

    always_comb begin
        if (dm_DMType == DM_WORD)
            dm_dout = {mem[dm_addr + 9'd3], mem[dm_addr + 9'd2], mem[dm_addr + 9'd1], mem[dm_addr]};
        else
            dm_dout = {24'h0, mem[dm_addr]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t f, input bit gap);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (gap) @(negedge clk);
        end
    endtask

    // Waits for done or err; drops any forced CPU store before the port is handed over.
    task automatic wait_end(output int n);
        n = 0;
        while (!(done || err) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cpu_DMWr = 1'b0;
        check("end_timeout", {31'b0, done | err}, 32'd1);
    endtask

    task automatic check_writes(input string tag, input int base, input byte_q_t exp_data);
        check({tag, "_count"}, wr_count - base, exp_data.size());
        foreach (exp_data[i]) begin
            if (base + i < wr_addr_log.size()) begin
                check({tag, "_addr"}, {23'b0, wr_addr_log[base + i]}, i);
                check({tag, "_data"}, {24'b0, wr_data_log[base + i]}, {24'b0, exp_data[i]});
            end
        end
    endtask

    initial begin
        int base;
        int lat;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cpu_DMWr = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_DMType = DM_WORD;
        repeat (2) @(negedge clk);
        check("rst_cpu_run", {31'b0, cpu_run}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_busy_done", {30'b0, busy, done}, 0);
        check("rst_dm_wr", {31'b0, dm_DMWr}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic frame: payload 13 05 00 00, checksum 0x18.
        base = wr_count;
        pulse_start();
        check("t1_busy", {31'b0, busy}, 1);
        send_frame('{8'h04, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h18}, 1'b0);
        wait_end(lat);
        check("t1_latency", lat, READBACK ? 4 : 0);
        check("t1_done_run", {30'b0, done, cpu_run}, 32'd3);
        check("t1_busy_off", {31'b0, busy}, 0);
        check_writes("t1_wr", base, '{8'h13, 8'h05, 8'h00, 8'h00});
        cpu_addr = 9'd0; cpu_DMType = DM_WORD;
        #1;
        check("t1_word_read", dm_dout, 32'h0000_0513);

        // Bad checksum, then recovery with a correct frame.
        pulse_start();
        check("t2_run_drop", {31'b0, cpu_run}, 0);
        send_frame('{8'h04, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h19}, 1'b0);
        wait_end(lat);
        check("t2_err", {31'b0, err}, 1);
        check("t2_run_ready", {30'b0, cpu_run, in_ready}, 0);
        pulse_start();
        check("t2_err_clr", {31'b0, err}, 0);
        send_frame('{8'h04, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h18}, 1'b0);
        wait_end(lat);
        check("t2_done", {31'b0, done}, 1);

        // Oversized length header 0x0201 = 513.
        base = wr_count;
        pulse_start();
        send_frame('{8'h01, 8'h02}, 1'b0);
        check("t3_err", {31'b0, err}, 1);
        check("t3_ready", {31'b0, in_ready}, 0);
        repeat (2) @(negedge clk);
        check("t3_no_writes", wr_count - base, 0);

        // Zero-length frames.
        base = wr_count;
        pulse_start();
        send_frame('{8'h00, 8'h00, 8'h00}, 1'b0);
        wait_end(lat);
        check("t4_latency", lat, 0);
        check("t4_done", {31'b0, done}, 1);
        check("t4_no_writes", wr_count - base, 0);
        pulse_start();
        send_frame('{8'h00, 8'h00, 8'h01}, 1'b0);
        wait_end(lat);
        check("t4_err", {30'b0, err, done}, 32'd2);

        // Gapped stream: payload AA BB CC DD, checksum 0x0E.
        base = wr_count;
        pulse_start();
        send_frame('{8'h04, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E}, 1'b1);
        wait_end(lat);
        check("t5_done", {31'b0, done}, 1);
        check_writes("t5_wr", base, '{8'hAA, 8'hBB, 8'hCC, 8'hDD});

        // Reset after the second payload byte; its write is already in flight.
        base = wr_count;
        pulse_start();
        send_frame('{8'h03, 8'h00, 8'h11, 8'h22}, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        check("t6_outputs", {26'b0, in_ready, busy, done, err, cpu_run, dm_DMWr}, 0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_idle_ready", {31'b0, in_ready}, 0);
        check_writes("t6_wr", base, '{8'h11, 8'h22});

        // CPU stores held on throughout the load must be dropped.
        base = wr_count;
        cpu_DMWr = 1'b1; cpu_addr = 9'd8; cpu_din = 32'hFFFF_FFFF; cpu_DMType = DM_WORD;
        pulse_start();
        send_frame('{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}, 1'b0);
        wait_end(lat);
        check("t7_latency", lat, READBACK ? 4 : 0);
        check("t7_done", {31'b0, done}, 1);
        check_writes("t7_wr", base, '{8'h01, 8'h02, 8'h03, 8'h04});
        cpu_addr = 9'd8;
        #1;
        check("t7_cpu_dropped", dm_dout, 32'h0);
        cpu_addr = 9'd0;
        #1;
        check("t7_word_read", dm_dout, 32'h0403_0201);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
